// File: rtl/tribus_pkg.sv
// Shared types and constants for the tridirectional transceiver sequencer.
// Pure definitions: no latency, no flow control.
package tribus_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      DRIVE = 2'd2,
      HOLD  = 2'd3
   } state_t;

   localparam logic [1:0] PORT_A  = 2'd0;
   localparam logic [1:0] PORT_B  = 2'd1;
   localparam logic [1:0] PORT_C  = 2'd2;

   localparam logic [1:0] SEL_OFF = 2'b11;
   localparam logic [2:0] G_OFF   = 3'b111;

   localparam int DEF_W          = 4;
   localparam int DEF_SETUP_CYC  = 1;
   localparam int DEF_ENABLE_CYC = 2;
   localparam int DEF_HOLD_CYC   = 1;
   localparam int PHASE_W        = 4;

   // Mask bit of a port inside the {A,B,C} destination field.
   function automatic logic [2:0] port_mask(input logic [1:0] port);
      logic [2:0] m;
      m = 3'b000;
      case (port)
         PORT_A:  m = 3'b100;
         PORT_B:  m = 3'b010;
         PORT_C:  m = 3'b001;
         default: m = 3'b000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/tribus_xfer_ctrl_if.sv
// Host request/ack, transceiver control pins and bus sample for tribus_xfer_ctrl.
// master = host/transceiver side, slave = the sequencer; req is held until ack.
interface tribus_xfer_ctrl_if #(
   parameter int W = 4
);
   logic         req;
   logic [1:0]   src;
   logic [2:0]   dst;
   logic         ack;
   logic         busy;
   logic         err;
   logic         cs;
   logic         s1;
   logic         s0;
   logic         ga;
   logic         gb;
   logic         gc;
   logic [W-1:0] bus_sample;
   logic [W-1:0] cap_data;
   logic         cap_valid;

   modport master (
      output req, src, dst, bus_sample,
      input  ack, busy, err, cs, s1, s0, ga, gb, gc, cap_data, cap_valid
   );

   modport slave (
      input  req, src, dst, bus_sample,
      output ack, busy, err, cs, s1, s0, ga, gb, gc, cap_data, cap_valid
   );
endinterface

// File: rtl/tribus_xfer_ctrl.sv
// Sequences cs/select/enables through SETUP, DRIVE, HOLD; ack after SETUP+ENABLE+HOLD cycles.
// req is ignored while busy; TRIBUS_BROADCAST_EN allows driving both non-source ports at once.
module tribus_xfer_ctrl
   import tribus_pkg::*;
#(
   parameter int W          = DEF_W,
   parameter int SETUP_CYC  = DEF_SETUP_CYC,
   parameter int ENABLE_CYC = DEF_ENABLE_CYC,
   parameter int HOLD_CYC   = DEF_HOLD_CYC
) (
   input  logic                clk,
   input  logic                clr_n,
   tribus_xfer_ctrl_if.slave   bus
);

   localparam logic [PHASE_W-1:0] SETUP_LD  = PHASE_W'(SETUP_CYC - 1);
   localparam logic [PHASE_W-1:0] ENABLE_LD = PHASE_W'(ENABLE_CYC - 1);
   localparam logic [PHASE_W-1:0] HOLD_LD   = PHASE_W'(HOLD_CYC - 1);

   state_t               state_q, state_nx;
   logic [PHASE_W-1:0]   cnt_q, cnt_nx;
   logic [1:0]           src_q, src_nx;
   logic [2:0]           dst_q, dst_nx;
   logic                 legal, dst_shape_ok;
   logic                 accept, reject, capture;

   logic                 cs_q, cs_nx;
   logic [1:0]           sel_q, sel_nx;
   logic [2:0]           g_q, g_nx;
   logic                 ack_q, ack_nx;
   logic                 busy_q, busy_nx;
   logic                 err_q;
   logic [W-1:0]         cap_data_q;
   logic                 cap_valid_q;

   always_comb begin
`ifdef TRIBUS_BROADCAST_EN
      dst_shape_ok = 1'b1;
`else
      dst_shape_ok = $onehot(bus.dst);
`endif
      legal = (bus.src != SEL_OFF) && (bus.dst != 3'b000) &&
              ((bus.dst & port_mask(bus.src)) == 3'b000) && dst_shape_ok;
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         src_q   <= PORT_A;
         dst_q   <= 3'b000;
      end else begin
         state_q <= state_nx;
         cnt_q   <= cnt_nx;
         src_q   <= src_nx;
         dst_q   <= dst_nx;
      end
   end

   always_comb begin
      state_nx = state_q;
      cnt_nx   = cnt_q;
      accept   = 1'b0;
      reject   = 1'b0;
      capture  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.req) begin
               if (legal) begin
                  accept   = 1'b1;
                  state_nx = SETUP;
                  cnt_nx   = SETUP_LD;
               end else begin
                  reject   = 1'b1;
               end
            end
         end
         SETUP: begin
            if (cnt_q == '0) begin
               state_nx = DRIVE;
               cnt_nx   = ENABLE_LD;
            end else begin
               cnt_nx   = cnt_q - 1'b1;
            end
         end
         DRIVE: begin
            if (cnt_q == '0) begin
               capture  = 1'b1;
               state_nx = HOLD;
               cnt_nx   = HOLD_LD;
            end else begin
               cnt_nx   = cnt_q - 1'b1;
            end
         end
         HOLD: begin
            if (cnt_q == '0) begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end else begin
               cnt_nx   = cnt_q - 1'b1;
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
      endcase

      src_nx = accept ? bus.src : src_q;
      dst_nx = accept ? bus.dst : dst_q;

      // Pins are decoded from the next state so every output leaves a flop.
      cs_nx   = (state_nx == IDLE);
      sel_nx  = (state_nx == IDLE)  ? SEL_OFF : src_nx;
      g_nx    = (state_nx == DRIVE) ? ~dst_nx : G_OFF;
      ack_nx  = (state_nx == HOLD) && (cnt_nx == '0);
      busy_nx = (state_nx != IDLE);
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         cs_q        <= 1'b1;
         sel_q       <= SEL_OFF;
         g_q         <= G_OFF;
         ack_q       <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
         cap_data_q  <= '0;
         cap_valid_q <= 1'b0;
      end else begin
         cs_q        <= cs_nx;
         sel_q       <= sel_nx;
         g_q         <= g_nx;
         ack_q       <= ack_nx;
         busy_q      <= busy_nx;
         err_q       <= reject;
         cap_valid_q <= capture;
         if (capture) begin
            cap_data_q <= bus.bus_sample;
         end
      end
   end

   assign bus.cs        = cs_q;
   assign bus.s1        = sel_q[1];
   assign bus.s0        = sel_q[0];
   assign bus.ga        = g_q[2];
   assign bus.gb        = g_q[1];
   assign bus.gc        = g_q[0];
   assign bus.ack       = ack_q;
   assign bus.busy      = busy_q;
   assign bus.err       = err_q;
   assign bus.cap_data  = cap_data_q;
   assign bus.cap_valid = cap_valid_q;

endmodule

// File: tb/tb_tribus_xfer_ctrl.sv
// Bench for tribus_xfer_ctrl: default-timing DUT plus a 3/1/2 phase-length DUT,
// checked cycle by cycle against a phase-window model of the pin sequence.
module tb_tribus_xfer_ctrl;

   localparam int W  = 4;
   localparam int S0 = 1, E0 = 2, H0 = 1;
   localparam int S1 = 3, E1 = 1, H1 = 2;
   localparam logic [9:0] OFF_PINS = 10'b1111110000;
   localparam logic [9:0] ERR_PINS = 10'b1111110010;

   logic         clk = 1'b0;
   logic         clr_n;
   logic         drv_req;
   logic [1:0]   drv_src;
   logic [2:0]   drv_dst;
   logic [W-1:0] drv_bus;
   logic         dut_sel;
   logic [9:0]   obs;
   logic [W-1:0] obs_cap;
   int           n_checks;
   int           n_errors;

   always #5 clk = ~clk;

   tribus_xfer_ctrl_if #(.W(W)) if_a ();
   tribus_xfer_ctrl_if #(.W(W)) if_b ();

   assign if_a.req        = drv_req & ~dut_sel;
   assign if_a.src        = drv_src;
   assign if_a.dst        = drv_dst;
   assign if_a.bus_sample = drv_bus;
   assign if_b.req        = drv_req & dut_sel;
   assign if_b.src        = drv_src;
   assign if_b.dst        = drv_dst;
   assign if_b.bus_sample = drv_bus;

   tribus_xfer_ctrl #(.W(W), .SETUP_CYC(S0), .ENABLE_CYC(E0), .HOLD_CYC(H0)) u_dut_a (
      .clk   (clk),
      .clr_n (clr_n),
      .bus   (if_a)
   );

   tribus_xfer_ctrl #(.W(W), .SETUP_CYC(S1), .ENABLE_CYC(E1), .HOLD_CYC(H1)) u_dut_b (
      .clk   (clk),
      .clr_n (clr_n),
      .bus   (if_b)
   );

   always_comb begin
      if (!dut_sel) begin
         obs     = {if_a.cs, if_a.s1, if_a.s0, if_a.ga, if_a.gb, if_a.gc,
                    if_a.ack, if_a.busy, if_a.err, if_a.cap_valid};
         obs_cap = if_a.cap_data;
      end else begin
         obs     = {if_b.cs, if_b.s1, if_b.s0, if_b.ga, if_b.gb, if_b.gc,
                    if_b.ack, if_b.busy, if_b.err, if_b.cap_valid};
         obs_cap = if_b.cap_data;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit model_legal(input int s, input logic [2:0] d);
      if (s == 3 || d == 3'b000) return 1'b0;
      if (d[2 - s]) return 1'b0;
`ifndef TRIBUS_BROADCAST_EN
      if ($countones(d) != 1) return 1'b0;
`endif
      return 1'b1;
   endfunction

   // Expected pins in cycle k after the accepting edge, from the phase windows.
   function automatic logic [9:0] exp_pins(input int k, input int s_len, input int e_len,
                                           input int h_len, input logic [1:0] s,
                                           input logic [2:0] d);
      bit         in_xfer, in_drive;
      logic [1:0] sel;
      logic [2:0] g;
      in_xfer  = (k >= 1) && (k <= s_len + e_len + h_len);
      in_drive = (k > s_len) && (k <= s_len + e_len);
      sel      = in_xfer ? s : 2'b11;
      g        = in_drive ? ~d : 3'b111;
      return {~in_xfer, sel, g, (k == s_len + e_len + h_len), in_xfer, 1'b0,
              (k == s_len + e_len + 1)};
   endfunction

   task automatic run_xfer(input logic [1:0] s, input logic [2:0] d, input bit chain,
                           input logic [1:0] ns, input logic [2:0] nd, input bit fixed,
                           input logic [W-1:0] fbus, input string name);
      int           sl, el, hl, tl;
      logic [9:0]   e;
      logic [W-1:0] exp_cap;
      sl = dut_sel ? S1 : S0;
      el = dut_sel ? E1 : E0;
      hl = dut_sel ? H1 : H0;
      tl = sl + el + hl;
      exp_cap = '0;
      drv_src = s;
      drv_dst = d;
      drv_req = 1'b1;
      drv_bus = W'($urandom);
      for (int k = 1; k <= tl + 1; k++) begin
         tick();
         e = exp_pins(k, sl, el, hl, s, d);
         n_checks++;
         if (obs !== e) begin
            n_errors++;
            $display("FAIL %s cycle %0d pins {cs,s,g,ack,busy,err,cap_valid}: got %b expected %b",
                     name, k, obs, e);
         end
         if (k == sl + el + 1) begin
            n_checks++;
            if (obs_cap !== exp_cap) begin
               n_errors++;
               $display("FAIL %s cap_data: got %h expected %h", name, obs_cap, exp_cap);
            end
         end
         drv_bus = (fixed && k > sl && k <= sl + el) ? fbus : W'($urandom);
         if (k == sl + el) exp_cap = drv_bus;
         if (k < tl) begin
            drv_src = 2'($urandom);
            drv_dst = 3'($urandom);
         end else if (k == tl) begin
            if (chain) begin
               drv_src = ns;
               drv_dst = nd;
            end else begin
               drv_req = 1'b0;
            end
         end
      end
   endtask

   task automatic run_reject(input logic [1:0] s, input logic [2:0] d, input string name);
      drv_src = s;
      drv_dst = d;
      drv_req = 1'b1;
      tick();
      drv_req = 1'b0;
      n_checks++;
      if (obs !== ERR_PINS) begin
         n_errors++;
         $display("FAIL %s err cycle pins: got %b expected %b", name, obs, ERR_PINS);
      end
      tick();
      n_checks++;
      if (obs !== OFF_PINS) begin
         n_errors++;
         $display("FAIL %s after err pins: got %b expected %b", name, obs, OFF_PINS);
      end
   endtask

   task automatic test_reset();
      clr_n = 1'b1;
      #2 clr_n = 1'b0;
      #2;
      for (int i = 0; i < 2; i++) begin
         dut_sel = i[0];
         #1;
         n_checks++;
         if (obs !== OFF_PINS || obs_cap !== '0) begin
            n_errors++;
            $display("FAIL reset dut%0d: got pins %b cap %h expected %b cap 0",
                     i, obs, obs_cap, OFF_PINS);
         end
      end
      dut_sel = 1'b0;
      @(negedge clk);
      clr_n = 1'b1;
      tick();
      n_checks++;
      if (obs !== OFF_PINS) begin
         n_errors++;
         $display("FAIL reset idle: got %b expected %b", obs, OFF_PINS);
      end
   endtask

   task automatic test_basic();
      run_xfer(2'd1, 3'b100, 1'b0, 2'd0, 3'b000, 1'b1, 4'hA, "basic_b_to_a");
      run_xfer(2'd2, 3'b010, 1'b0, 2'd0, 3'b000, 1'b1, 4'h5, "basic_c_to_b");
   endtask

   task automatic test_illegal();
      run_reject(2'd3, 3'b100, "illegal_src3");
      run_reject(2'd1, 3'b000, "illegal_dst0");
      run_reject(2'd0, 3'b100, "illegal_self");
   endtask

   task automatic test_broadcast();
      if (model_legal(0, 3'b011))
         run_xfer(2'd0, 3'b011, 1'b0, 2'd0, 3'b000, 1'b0, 4'h0, "broadcast");
      else
         run_reject(2'd0, 3'b011, "broadcast");
   endtask

   task automatic test_back_to_back();
      run_xfer(2'd1, 3'b001, 1'b1, 2'd2, 3'b100, 1'b0, 4'h0, "b2b_first");
      run_xfer(2'd2, 3'b100, 1'b1, 2'd0, 3'b001, 1'b0, 4'h0, "b2b_second");
      run_xfer(2'd0, 3'b001, 1'b0, 2'd0, 3'b000, 1'b0, 4'h0, "b2b_third");
   endtask

   task automatic test_random();
      logic [1:0] s;
      logic [2:0] d;
      for (int i = 0; i < 24; i++) begin
         s = 2'($urandom_range(0, 3));
         d = 3'($urandom_range(0, 7));
         if (model_legal(int'(s), d))
            run_xfer(s, d, 1'b0, 2'd0, 3'b000, 1'b0, 4'h0, "random_xfer");
         else
            run_reject(s, d, "random_reject");
      end
   endtask

   task automatic test_param_sweep();
      dut_sel = 1'b1;
      run_xfer(2'd0, 3'b010, 1'b1, 2'd2, 3'b010, 1'b1, 4'h3, "sweep_a_to_b");
      run_xfer(2'd2, 3'b010, 1'b0, 2'd0, 3'b000, 1'b1, 4'hC, "sweep_c_to_b");
      run_reject(2'd1, 3'b010, "sweep_illegal");
      dut_sel = 1'b0;
   endtask

   task automatic test_reset_mid_drive();
      logic [9:0] e;
      drv_src = 2'd2;
      drv_dst = 3'b100;
      drv_req = 1'b1;
      for (int k = 1; k <= S0 + 1; k++) tick();
      e = exp_pins(S0 + 1, S0, E0, H0, 2'd2, 3'b100);
      n_checks++;
      if (obs !== e) begin
         n_errors++;
         $display("FAIL mid_drive pre-reset pins: got %b expected %b", obs, e);
      end
      drv_req = 1'b0;
      #2 clr_n = 1'b0;
      #1;
      n_checks++;
      if (obs !== OFF_PINS || obs_cap !== '0) begin
         n_errors++;
         $display("FAIL mid_drive async reset: got pins %b cap %h expected %b cap 0",
                  obs, obs_cap, OFF_PINS);
      end
      #1 clr_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         n_checks++;
         if (obs !== OFF_PINS) begin
            n_errors++;
            $display("FAIL mid_drive post-reset cycle %0d: got %b expected %b", k, obs, OFF_PINS);
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      dut_sel  = 1'b0;
      drv_req  = 1'b0;
      drv_src  = 2'd0;
      drv_dst  = 3'b000;
      drv_bus  = '0;
      clr_n    = 1'b1;
      test_reset();
      test_basic();
      test_illegal();
      test_broadcast();
      test_back_to_back();
      test_random();
      test_param_sweep();
      test_reset_mid_drive();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
